// File: rtl/sd_arbiter.sv
// sd_arbiter: shares the single SD block-access port of the I/O controller
// between N (1..4) core-side requesters. Requesters are served one sector at a time,
// in round-robin order. An optional ack timeout returns a stuck command to IDLE.
//
// Ports:
//   clk_sys, reset          - system clock; synchronous active-high reset
//   req_lba/req_rd/req_wr   - per-requester command (LBA i at [32i+31:32i])
//   req_ack/req_buff_wr     - per-requester gated copies of sd_ack/sd_buff_wr
//   req_buff_din            - per-requester write data (byte i at [8i+7:8i])
//   req_err                 - one-cycle timeout pulse to the granted requester
//   sd_lba/sd_rd/sd_wr      - command to the I/O controller
//   sd_ack/sd_buff_wr       - handshake and byte strobe from the I/O controller
//   sd_buff_din             - write data muxed from the granted requester
//   busy/grant              - status: not IDLE / current or last grant index
module sd_arbiter #(
  parameter int N           = 2,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [32*N-1:0]   req_lba,
  input  logic [N-1:0]      req_rd,
  input  logic [N-1:0]      req_wr,
  output logic [N-1:0]      req_ack,
  output logic [N-1:0]      req_buff_wr,
  input  logic [8*N-1:0]    req_buff_din,
  output logic [N-1:0]      req_err,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  output logic              busy,
  output logic [1:0]        grant
);

  // Wide enough to hold ACK_TIMEOUT (and at least one bit when disabled).
  localparam int CW = $clog2(ACK_TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [31:0]     lba_q, lba_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [N-1:0]    err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Requester views padded to four slots so a 2-bit index always fits exactly.
  logic [3:0]       pend4_s;
  logic [3:0]       wr4_s;
  logic [3:0][31:0] lba4_s;
  logic [3:0][7:0]  din4_s;
  logic [3:0]       sel4_s;
  logic             found_hi_s, found_lo_s;
  logic [1:0]       pick_hi_s, pick_lo_s, pick_s;
  logic             active_s;
  logic             timeout_s;

  // Pad the per-requester buses into fixed four-entry arrays.
  always_comb begin
    pend4_s = 4'b0000;
    wr4_s   = 4'b0000;
    lba4_s  = '0;
    din4_s  = '0;
    for (int i = 0; i < N; i++) begin
      pend4_s[i] = req_rd[i] | req_wr[i];
      wr4_s[i]   = req_wr[i];
      lba4_s[i]  = req_lba[32*i +: 32];
      din4_s[i]  = req_buff_din[8*i +: 8];
    end
  end

  // Round-robin pick: lowest pending index above last, else lowest pending overall.
  // Loops run downward so the lowest qualifying index is assigned last and wins.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    pick_hi_s  = 2'd0;
    pick_lo_s  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend4_s[i]) begin
        found_lo_s = 1'b1;
        pick_lo_s  = 2'(i);
      end else begin
        found_lo_s = found_lo_s;
      end
      if (pend4_s[i] && (2'(i) > last_q)) begin
        found_hi_s = 1'b1;
        pick_hi_s  = 2'(i);
      end else begin
        found_hi_s = found_hi_s;
      end
    end
    if (found_hi_s) begin
      pick_s = pick_hi_s;
    end else begin
      pick_s = pick_lo_s;
    end
  end

  assign sel4_s    = 4'b0001 << grant_q;
  assign active_s  = (state_q == S_ISSUE) || (state_q == S_XFER);
  assign timeout_s = (ACK_TIMEOUT != 0) && (cnt_q == CW'(ACK_TIMEOUT - 1));

  // Next-state logic for the transfer FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found_lo_s) begin
          grant_d = pick_s;
          lba_d   = lba4_s[pick_s];
          // A write wins when both read and write are requested.
          wr_d    = wr4_s[pick_s];
          rd_d    = ~wr4_s[pick_s];
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if (timeout_s) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = sel4_s[N-1:0];
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          state_d = S_DONE;
        end else begin
          state_d = S_XFER;
        end
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'd0;
      // Start the search at requester 0 after reset.
      last_q  <= 2'(N - 1);
      lba_q   <= 32'h0000_0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ack and byte strobe reach only the granted requester, and only mid-transfer.
  assign req_ack     = sel4_s[N-1:0] & {N{sd_ack & active_s}};
  assign req_buff_wr = sel4_s[N-1:0] & {N{sd_buff_wr & active_s}};
  assign sd_buff_din = din4_s[grant_q];
  assign req_err     = err_q;
  assign sd_lba      = lba_q;
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign busy        = (state_q != S_IDLE);
  assign grant       = grant_q;

endmodule

// File: doc/sd_arbiter.md
# sd_arbiter

Shares the single SD block-access port of the MiST I/O controller (sd_lba/sd_rd/sd_wr/sd_ack plus the 512-byte sd_buff byte interface) between up to four core-side requesters, e.g. two floppy drives and a hard-disk image. Sits in clk_sys between the I/O controller and the disk controllers. Each requester sees a private copy of the port with identical handshake semantics. Arbitration is round-robin, with an optional ack timeout.

## Interface
- N, 2, number of requesters (1..4)
- ACK_TIMEOUT, 0, clk_sys cycles to wait for sd_ack after a command is issued; 0 disables the timeout
- clk_sys  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- req_lba  in  32*N  per-requester LBA; requester i uses bits [32i+31:32i]
- req_rd  in  N  per-requester read request; held by the requester until its req_ack rises
- req_wr  in  N  per-requester write request; same rule as req_rd
- req_ack  out  N  per-requester acknowledge; reset 0
- req_buff_wr  out  N  per-requester buffer write strobe; reset 0
- req_buff_din  in  8*N  per-requester buffer read data, used during writes to SD
- req_err  out  N  one-cycle timeout pulse per requester; reset 0
- sd_lba  out  32  to I/O controller; reset 0
- sd_rd, sd_wr  out  1 each  to I/O controller; reset 0
- sd_ack  in  1  from I/O controller
- sd_buff_wr  in  1  from I/O controller
- sd_buff_din  out  8  to I/O controller; mux of req_buff_din selected by grant
- busy  out  1  high in every state except IDLE; reset 0
- grant  out  2  index of the current or last granted requester; reset 0
- sd_buff_addr and sd_buff_dout are broadcast directly to every requester and do not pass through this block.

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- **IDLE**
  - pending[i] = req_rd[i] | req_wr[i].
  - Select the first pending requester, searching from (last + 1) mod N and wrapping.
  - Latch grant, sd_lba <= req_lba[grant], and the op. req_wr wins if both req_rd and req_wr are high for the same requester.
  - Go to ISSUE.
- **ISSUE**
  - Drive sd_rd or sd_wr = 1.
  - On sd_ack = 1: clear sd_rd/sd_wr on that same edge and go to XFER.
  - If ACK_TIMEOUT != 0 and the cycle counter reaches ACK_TIMEOUT: clear sd_rd/sd_wr, pulse req_err[grant] for one cycle, and go to DONE.
- **XFER**
  - Hold until sd_ack = 0, then go to DONE.
- **DONE**
  - Lasts one cycle.
  - last <= grant, then go to IDLE.
  - The requester has had at least one cycle after ack to drop its request. A request still high in the following IDLE is treated as a new request.
- Gating:
  - req_ack[i] = sd_ack & (state is ISSUE or XFER) & (grant == i). Combinational, so the requester sees the ack in the same cycle as the I/O controller raises it.
  - req_buff_wr[i] = sd_buff_wr & (state is ISSUE or XFER) & (grant == i).
  - sd_buff_din = req_buff_din[grant], combinational.
- N = 1 degenerates to a pass-through with the same state sequence.
- sd_ack or sd_buff_wr arriving in IDLE or DONE are ignored and not forwarded to any requester.
- Reset mid-transfer:
  - All outputs return to their reset values, state goes to IDLE, last = N-1 (so requester 0 is searched first).
  - Acks from an in-flight transfer are dropped. Requesters must re-request.
- The timeout counter is clog2-sized to hold ACK_TIMEOUT. It clears on entry to ISSUE and does not count in other states.

## Timing
- Request seen in IDLE at edge k → ISSUE with sd_rd/sd_wr high and sd_lba valid from edge k+1.
- sd_lba is stable from ISSUE until the next IDLE selection.
- sd_rd/sd_wr fall on the first edge where sd_ack = 1.
- Back-to-back transfers: minimum gap from sd_ack falling to the next sd_rd rising is 2 cycles (DONE, then IDLE).
- Throughput is one sector transfer at a time. There is no preemption.

## Test plan
- Single read, N=2:
  - Stimulus: req_rd[0] = 1 with lba 0x00000123. The I/O model acks after 5 cycles, then sends 512 sd_buff_wr pulses.
  - Response: sd_rd high one cycle after the request and low the edge ack rises; sd_lba = 0x123; 512 req_buff_wr[0] pulses; req_buff_wr[1] = 0; busy low 2 cycles after ack falls.
- Contention:
  - Stimulus: req_rd[0] and req_rd[1] asserted together from reset, each re-requesting after completion.
  - Response: grants alternate 0,1,0,1; no requester is served twice in a row while the other is pending.
- Write path:
  - Stimulus: req_wr[1] with req_buff_din[1] = 0xA5, req_buff_din[0] = 0x3C.
  - Response: sd_wr = 1, sd_rd = 0, and sd_buff_din = 0xA5 throughout XFER.
- Both read and write asserted on requester 0:
  - Response: only sd_wr is asserted.
- Timeout:
  - Stimulus: ACK_TIMEOUT = 16 and sd_ack held at 0.
  - Response: sd_rd drops after 16 ISSUE cycles; req_err[grant] pulses exactly one cycle; returns to IDLE.
- Reset mid-XFER:
  - Stimulus: assert reset after the 100th sd_buff_wr.
  - Response: all outputs are 0 the next cycle; later sd_buff_wr pulses are not forwarded; a new req_rd[1] after reset is granted normally.
